regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue_pkg.sv | 14 +
 rtl/wbq_fwd_match.sv | 31 +++
 rtl/regfile_wb_queue.sv | 115 +++++++++++
 tb/tb_regfile_wb_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
package regfile_wb_queue_pkg;

  localparam int          DATA_W   = 64;
  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd31;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup over the pending write-back entries.
// Entries are presented oldest (index 0) to youngest (index DEPTH-1),
// so the highest-indexed valid match is the youngest and wins.
module wbq_fwd_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic      [DEPTH-1:0] valid,
  input  logic      [REG_W-1:0] lookup,
  output logic                  hit,
  output logic      [DATA_W-1:0] data
);

  // Priority scan: later (younger) matches override earlier ones.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hit  = 1'b0;
    data = '0;
    if (lookup != REG_ZERO) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && entries[i].reg_idx == lookup) begin
          hit  = 1'b1;
          data = entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file.
// Buffers up to DEPTH pending writes, drains them in FIFO order when
// drain_hold is low, drops writes to X31, and optionally forwards the
// youngest pending value for two read ports.
// Build option: define WBQ_FORWARD_EN to include the forwarding lookup;
// without it the forwarding outputs are tied to zero.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_hold,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  ReadRegister1,
  input  logic [REG_W-1:0]  ReadRegister2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  wb_entry_t        mem [DEPTH];

  logic has_entry;
  logic push;
  logic pop;

  assign has_entry = (count != '0);
  assign in_ready  = (count < DEPTH_C);
  // Writes to X31 are accepted but never stored.
  assign push      = in_valid && in_ready && (in_reg != REG_ZERO);
  assign pop       = RegWrite;

  assign RegWrite      = has_entry && !drain_hold;
  assign WriteRegister = has_entry ? mem[rd_ptr].reg_idx : '0;
  assign WriteData     = has_entry ? mem[rd_ptr].data    : '0;

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; outputs are gated by count so stale data never shows.
    if (push) begin
      mem[wr_ptr] <= '{reg_idx: in_reg, data: in_data};
    end
  end

`ifdef WBQ_FORWARD_EN
  wb_entry_t [DEPTH-1:0] age_entries;
  logic      [DEPTH-1:0] age_valid;

  // Rotate storage into age order (oldest first) with an occupancy mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entries[i] = mem[rd_ptr + PTR_W'(i)];
      age_valid[i]   = ((PTR_W + 1)'(i) < count);
    end
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (age_entries),
    .valid   (age_valid),
    .lookup  (ReadRegister1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (age_entries),
    .valid   (age_valid),
    .lookup  (ReadRegister2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );
`else
  logic unused_lookup;

  assign unused_lookup = ^{ReadRegister1, ReadRegister2};
  assign fwd_hit1      = 1'b0;
  assign fwd_hit2      = 1'b0;
  assign fwd_data1     = '0;
  assign fwd_data2     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue (DEPTH = 4).
// A scoreboard queue holds the expected pending entries; each cycle the
// outputs are compared against it before the clock edge.
module tb_regfile_wb_queue;
  import regfile_wb_queue_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_reg;
  logic [DATA_W-1:0] in_data;
  logic              drain_hold;
  logic              RegWrite;
  logic [REG_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [REG_W-1:0]  ReadRegister1;
  logic [REG_W-1:0]  ReadRegister2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  int n_checks = 0;
  int n_pass   = 0;

  wb_entry_t sb [$];

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .drain_hold    (drain_hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference forwarding: youngest pending match, nothing for X31.
  function automatic void fwd_model(input logic [4:0] idx, output logic hit,
                                    output logic [63:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WBQ_FORWARD_EN
    if (idx != REG_ZERO) begin
      foreach (sb[i]) begin
        if (sb[i].reg_idx == idx) begin
          hit  = 1'b1;
          data = sb[i].data;
        end
      end
    end
`endif
  endfunction

  task automatic drive(input logic v, input logic [4:0] r, input logic [63:0] d,
                       input logic hold);
    in_valid   = v;
    in_reg     = r;
    in_data    = d;
    drain_hold = hold;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    logic        exp_we;
    logic        accept;
    logic        h;
    logic [63:0] d;
    #1;
    exp_we = (sb.size() != 0) && !drain_hold;
    accept = in_valid && (sb.size() < DEPTH);
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    check("RegWrite", 64'(RegWrite), 64'(exp_we));
    check("WriteRegister", 64'(WriteRegister), sb.size() != 0 ? 64'(sb[0].reg_idx) : 64'd0);
    check("WriteData", WriteData, sb.size() != 0 ? sb[0].data : 64'd0);
    fwd_model(ReadRegister1, h, d);
    check("fwd_hit1", 64'(fwd_hit1), 64'(h));
    check("fwd_data1", fwd_data1, d);
    fwd_model(ReadRegister2, h, d);
    check("fwd_hit2", 64'(fwd_hit2), 64'(h));
    check("fwd_data2", fwd_data2, d);
    @(posedge clk);
    if (reset) begin
      sb.delete();
    end else begin
      if (exp_we) void'(sb.pop_front());
      if (accept && in_reg != REG_ZERO) sb.push_back('{reg_idx: in_reg, data: in_data});
    end
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drain();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    reset         = 1'b1;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single push drains on the following cycle.
    tick();
    drive(1'b1, 5'd3, 64'hAA, 1'b0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    tick();

    // Fill with drain held; fifth push refused; then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 64'h100 + 64'(i), 1'b1);
      tick();
    end
    drain();

    // Youngest of two matching entries forwards; in-flight entry excluded.
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd7;
    drive(1'b1, 5'd5, 64'h11, 1'b1); tick();
    drive(1'b1, 5'd5, 64'h22, 1'b1); tick();
    drive(1'b1, 5'd7, 64'h77, 1'b1); tick();
    drive(1'b1, 5'd5, 64'h33, 1'b1); tick();
    drain();

    // Writes to X31 are dropped; lookup of 31 never hits.
    ReadRegister1 = REG_ZERO;
    drive(1'b1, REG_ZERO, 64'hDEAD, 1'b0); tick();
    drive(1'b1, REG_ZERO, 64'hBEEF, 1'b1); tick();
    drain();

    // Full queue while head drains: same-cycle push refused.
    ReadRegister1 = 5'd9;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'd9 + 5'(i), rnd64(), 1'b1);
      tick();
    end
    drive(1'b1, 5'd20, 64'h2020, 1'b0); tick();
    drive(1'b1, 5'd21, 64'h2121, 1'b0); tick();
    drain();

    // Steady push+pop at count 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'($urandom_range(0, 30)), rnd64(), 1'b1);
      tick();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ReadRegister1 = 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      drive(1'b1, 5'($urandom_range(0, 30)), rnd64(), 1'b0);
      tick();
    end
    drain();

    // Reset with entries pending, including one accepted during reset.
    ReadRegister1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd12, rnd64(), 1'b1);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 5'd12, 64'h5A5A, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    tick();

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      ReadRegister1 = 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd64(),
            1'($urandom_range(0, 3) == 0));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
